// File: rtl/rename_pkg.sv
// Rename stage shared types: tag widths, RAT image and the renamed-op bundle.
package rename_pkg;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int PW = $clog2(PHYS_REGS);

  typedef logic [PW-1:0] phys_tag_t;
  typedef logic [4:0] arch_idx_t;
  typedef logic [ARCH_REGS-1:0][PW-1:0] rat_t;

  typedef struct packed {
    phys_tag_t prs1;
    phys_tag_t prs2;
    phys_tag_t prd;
    phys_tag_t old_prd;
    logic      prs1_rdy;
    logic      prs2_rdy;
    logic      rd_we;
  } ren_out_t;

  function automatic rat_t rat_identity();
    rat_t r;
    for (int i = 0; i < ARCH_REGS; i++)
      r[i] = PW'(i);
    return r;
  endfunction
endpackage

// File: rtl/rename_map_if.sv
// Decode, free-list, issue, writeback and retire signals of the rename stage.
interface rename_map_if;
  import rename_pkg::*;

  logic      in_valid;
  logic      in_ready;
  arch_idx_t in_rs1;
  arch_idx_t in_rs2;
  arch_idx_t in_rd;
  logic      in_rd_we;
  logic      fl_alloc_valid;
  phys_tag_t fl_alloc_phys;
  logic      fl_pop;
  logic      out_valid;
  logic      out_ready;
  phys_tag_t out_prs1;
  phys_tag_t out_prs2;
  phys_tag_t out_prd;
  phys_tag_t out_old_prd;
  logic      out_prs1_rdy;
  logic      out_prs2_rdy;
  logic      out_rd_we;
  logic      wb_en;
  phys_tag_t wb_phys;
  logic      commit_en;
  arch_idx_t commit_rd;
  phys_tag_t commit_phys;
  logic      free_en;
  phys_tag_t free_phys;
  logic      flush;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
    output fl_alloc_valid, fl_alloc_phys, out_ready,
    output wb_en, wb_phys, flush,
    output commit_en, commit_rd, commit_phys,
    input  in_ready, fl_pop, out_valid,
    input  out_prs1, out_prs2, out_prd, out_old_prd,
    input  out_prs1_rdy, out_prs2_rdy, out_rd_we,
    input  free_en, free_phys
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
    input  fl_alloc_valid, fl_alloc_phys, out_ready,
    input  wb_en, wb_phys, flush,
    input  commit_en, commit_rd, commit_phys,
    output in_ready, fl_pop, out_valid,
    output out_prs1, out_prs2, out_prd, out_old_prd,
    output out_prs1_rdy, out_prs2_rdy, out_rd_we,
    output free_en, free_phys
  );
endinterface

// File: rtl/rename_map_rat_table.sv
// Arch-to-phys alias table: NR read ports, one write port, bulk load.
module rat_table
  import rename_pkg::*;
#(
  parameter int NR = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  arch_idx_t [NR-1:0]   rd_idx,
  output phys_tag_t [NR-1:0]   rd_tag,
  input  logic                 we,
  input  arch_idx_t            wr_idx,
  input  phys_tag_t            wr_tag,
  input  logic                 load,
  input  rat_t                 load_map,
  output rat_t                 map
);
  rat_t map_q;
  rat_t map_d;

  // A bulk load replaces the whole image, so it shadows the write port.
  always_comb begin
    map_d = map_q;
    if (load)
      map_d = load_map;
    else if (we)
      map_d[wr_idx] = wr_tag;
  end

  always_ff @(posedge clk) begin
    if (rst)
      map_q <= rat_identity();
    else
      map_q <= map_d;
  end

  always_comb begin
    rd_tag = '0;
    for (int i = 0; i < NR; i++)
      rd_tag[i] = map_q[rd_idx[i]];
  end

  assign map = map_q;
endmodule

// File: rtl/rename_map.sv
// Rename stage: speculative/committed RATs, ready bits, one-deep output slot.
module rename_map
  import rename_pkg::*;
(
  input logic        clk,
  input logic        rst,
  rename_map_if.slave io
);
  logic      need_alloc;
  logic      in_ready;
  logic      fire;
  logic      alloc;
  logic      commit_ok;
  phys_tag_t spec_rs1;
  phys_tag_t spec_rs2;
  phys_tag_t cmt_old;
  rat_t      spec_map;
  rat_t      cmt_map;
  rat_t      cmt_next;

  logic                 out_valid_q, out_valid_d;
  ren_out_t             out_q, out_d;
  logic [PHYS_REGS-1:0] rdy_q, rdy_d;
  logic                 free_en_q, free_en_d;
  phys_tag_t            free_phys_q, free_phys_d;

  assign need_alloc = io.in_rd_we && (io.in_rd != '0);
  assign in_ready = (!out_valid_q || io.out_ready) && !io.flush
                 && (!need_alloc || io.fl_alloc_valid);
  assign fire  = io.in_valid && in_ready;
  assign alloc = fire && need_alloc;
  assign commit_ok = io.commit_en && (io.commit_rd != '0);

  rat_table #(.NR(2)) u_spec (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   ({io.in_rs2, io.in_rs1}),
    .rd_tag   ({spec_rs2, spec_rs1}),
    .we       (alloc),
    .wr_idx   (io.in_rd),
    .wr_tag   (io.fl_alloc_phys),
    .load     (io.flush),
    .load_map (cmt_next),
    .map      (spec_map)
  );

  rat_table #(.NR(1)) u_cmt (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (io.commit_rd),
    .rd_tag   (cmt_old),
    .we       (commit_ok),
    .wr_idx   (io.commit_rd),
    .wr_tag   (io.commit_phys),
    .load     (1'b0),
    .load_map ('0),
    .map      (cmt_map)
  );

  // Flush restores the committed view including a same-cycle retirement.
  always_comb begin
    cmt_next = cmt_map;
    if (commit_ok)
      cmt_next[io.commit_rd] = io.commit_phys;
  end

  function automatic logic src_rdy(phys_tag_t t);
    return (t == '0) || rdy_q[t]
        || (io.wb_en && io.wb_phys == t);
  endfunction

  always_comb begin
    rdy_d = rdy_q;
    if (io.wb_en)
      rdy_d[io.wb_phys] = 1'b1;
    if (alloc)
      rdy_d[io.fl_alloc_phys] = 1'b0;
    if (io.flush)
      rdy_d = '1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (io.flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d    = 1'b1;
      out_d.prs1     = spec_rs1;
      out_d.prs2     = spec_rs2;
      out_d.prs1_rdy = src_rdy(spec_rs1);
      out_d.prs2_rdy = src_rdy(spec_rs2);
      out_d.rd_we    = need_alloc;
      out_d.prd      = need_alloc ? io.fl_alloc_phys : '0;
      out_d.old_prd  = need_alloc ? spec_map[io.in_rd] : '0;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    free_en_d   = commit_ok;
    free_phys_d = commit_ok ? cmt_old : free_phys_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rdy_q       <= '1;
      free_en_q   <= 1'b0;
      free_phys_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rdy_q       <= rdy_d;
      free_en_q   <= free_en_d;
      free_phys_q <= free_phys_d;
    end
  end

  assign io.in_ready     = in_ready;
  assign io.fl_pop       = alloc;
  assign io.out_valid    = out_valid_q;
  assign io.out_prs1     = out_q.prs1;
  assign io.out_prs2     = out_q.prs2;
  assign io.out_prd      = out_q.prd;
  assign io.out_old_prd  = out_q.old_prd;
  assign io.out_prs1_rdy = out_q.prs1_rdy;
  assign io.out_prs2_rdy = out_q.prs2_rdy;
  assign io.out_rd_we    = out_q.rd_we;
  assign io.free_en      = free_en_q;
  assign io.free_phys    = free_phys_q;
endmodule

// File: tb/tb_rename_map.sv
// Scoreboard bench for rename_map: directed plan then random traffic.
module tb_rename_map;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_map_if bus();

  rename_map dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    bit       iv;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
    bit       we;
    bit       fav;
    bit [5:0] fap;
    bit       ordy;
    bit       wb;
    bit [5:0] wbp;
    bit       ce;
    bit [4:0] crd;
    bit [5:0] cph;
    bit       fl;
  } stim_t;

  typedef struct {
    int p1;
    int p2;
    int pd;
    int po;
    bit r1;
    bit r2;
    bit we;
  } exp_t;

  exp_t q[$];
  int   spec_m[ARCH_REGS];
  int   cmt_m[ARCH_REGS];
  bit   rdy_m[PHYS_REGS];
  bit   ov_m;
  bit   fe_m;
  int   fp_m;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.ordy = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.in_valid       = s.iv;
    bus.in_rs1         = s.rs1;
    bus.in_rs2         = s.rs2;
    bus.in_rd          = s.rd;
    bus.in_rd_we       = s.we;
    bus.fl_alloc_valid = s.fav;
    bus.fl_alloc_phys  = s.fap;
    bus.out_ready      = s.ordy;
    bus.wb_en          = s.wb;
    bus.wb_phys        = s.wbp;
    bus.commit_en      = s.ce;
    bus.commit_rd      = s.crd;
    bus.commit_phys    = s.cph;
    bus.flush          = s.fl;
  endtask

  // One clock of stimulus; the model advances as the DUT will at the edge.
  task automatic step(input stim_t s);
    bit   need, erdy, fire;
    exp_t e;
    @(negedge clk);
    #1;
    chk("out_valid", bus.out_valid, ov_m);
    chk("free_en", bus.free_en, fe_m);
    if (fe_m) chk("free_phys", bus.free_phys, fp_m);
    drive(s);
    #1;
    need = s.we && s.rd != 0;
    erdy = (!ov_m || s.ordy) && !s.fl && (!need || s.fav);
    fire = s.iv && erdy;
    chk("in_ready", bus.in_ready, erdy);
    chk("fl_pop", bus.fl_pop, fire && need);
    if (fire) begin
      e.p1 = spec_m[s.rs1];
      e.p2 = spec_m[s.rs2];
      e.r1 = e.p1 == 0 || rdy_m[e.p1] || (s.wb && s.wbp == e.p1);
      e.r2 = e.p2 == 0 || rdy_m[e.p2] || (s.wb && s.wbp == e.p2);
      e.we = need;
      e.pd = need ? int'(s.fap) : 0;
      e.po = need ? spec_m[s.rd] : 0;
      q.push_back(e);
    end
    if (s.wb) rdy_m[s.wbp] = 1'b1;
    if (fire && need) begin
      spec_m[s.rd] = s.fap;
      rdy_m[s.fap] = 1'b0;
    end
    fe_m = s.ce && s.crd != 0;
    if (fe_m) begin
      fp_m = cmt_m[s.crd];
      cmt_m[s.crd] = s.cph;
    end
    if (s.fl) begin
      if (ov_m && !s.ordy) void'(q.pop_back());
      spec_m = cmt_m;
      foreach (rdy_m[i]) rdy_m[i] = 1'b1;
      ov_m = 1'b0;
    end else begin
      ov_m = fire ? 1'b1 : (s.ordy ? 1'b0 : ov_m);
    end
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consume the presented op whenever the issue side accepts it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got prd %0d expected none",
                   bus.out_prd);
        end else begin
          e = q.pop_front();
          chk("sb_prs1", bus.out_prs1, e.p1);
          chk("sb_prs2", bus.out_prs2, e.p2);
          chk("sb_prd", bus.out_prd, e.pd);
          chk("sb_old_prd", bus.out_old_prd, e.po);
          chk("sb_rdy1", bus.out_prs1_rdy, e.r1);
          chk("sb_rdy2", bus.out_prs2_rdy, e.r2);
          chk("sb_rd_we", bus.out_rd_we, e.we);
        end
      end
    end
  end

  always @(posedge clk)
    if (!rst)
      assert (!(bus.fl_pop && bus.wb_en
                && bus.wb_phys == bus.fl_alloc_phys))
      else $error("FAIL wb_alloc_collision: tag %0d", bus.wb_phys);

  initial begin
    stim_t s;
    drive(idle());
    for (int i = 0; i < ARCH_REGS; i++) begin
      spec_m[i] = i;
      cmt_m[i] = i;
    end
    foreach (rdy_m[i]) rdy_m[i] = 1'b1;
    ov_m = 0;
    fe_m = 0;
    fp_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_free_en", bus.free_en, 0);
    chk("rst_fl_pop", bus.fl_pop, 0);
    chk("rst_free_phys", bus.free_phys, 0);
    chk("rst_out_prd", bus.out_prd, 0);
    chk("rst_out_prs1", bus.out_prs1, 0);

    s = idle();
    s.iv = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 5;
    s.we = 1; s.fav = 1; s.fap = 32;
    step(s);
    post();
    chk("add_prs1", bus.out_prs1, 1);
    chk("add_prs2", bus.out_prs2, 2);
    chk("add_prd", bus.out_prd, 32);
    chk("add_old_prd", bus.out_old_prd, 5);
    chk("add_rdy1", bus.out_prs1_rdy, 1);
    chk("add_rdy2", bus.out_prs2_rdy, 1);

    s.rs1 = 5; s.rs2 = 5; s.rd = 6; s.fap = 33;
    step(s);
    post();
    chk("dep_prs1", bus.out_prs1, 32);
    chk("dep_prs2", bus.out_prs2, 32);
    chk("dep_rdy1", bus.out_prs1_rdy, 0);
    chk("dep_prd", bus.out_prd, 33);

    s.rs1 = 5; s.rs2 = 6; s.rd = 7; s.fap = 34;
    s.wb = 1; s.wbp = 32;
    step(s);
    post();
    chk("byp_rdy1", bus.out_prs1_rdy, 1);
    chk("byp_rdy2", bus.out_prs2_rdy, 0);

    s = idle();
    s.iv = 1; s.rs1 = 1; s.rs2 = 3; s.rd = 8; s.we = 1; s.fav = 0;
    step(s);
    post();
    chk("empty_no_fire", bus.out_valid, 0);
    s.we = 0;
    step(s);
    post();
    chk("store_valid", bus.out_valid, 1);
    chk("store_prd", bus.out_prd, 0);
    chk("store_rd_we", bus.out_rd_we, 0);

    s = idle();
    s.iv = 1; s.rs1 = 4; s.rd = 9; s.we = 1; s.fav = 1; s.fap = 35;
    s.ordy = 0;
    for (int i = 0; i < 3; i++) begin
      step(s);
      post();
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_prs1", bus.out_prs1, 1);
      chk("stall_prs2", bus.out_prs2, 3);
    end
    s.ordy = 1;
    step(s);
    post();
    chk("release_prd", bus.out_prd, 35);

    s = idle();
    s.ce = 1; s.crd = 5; s.cph = 32;
    step(s);
    post();
    chk("commit_free_en", bus.free_en, 1);
    chk("commit_free_phys", bus.free_phys, 5);
    s.crd = 0; s.cph = 40;
    step(s);
    post();
    chk("x0_no_free", bus.free_en, 0);

    s = idle();
    s.iv = 1; s.rd = 5; s.we = 1; s.fav = 1; s.fap = 40;
    step(s);
    s.fl = 1; s.ordy = 0; s.rd = 10; s.fap = 41;
    step(s);
    post();
    chk("flush_drop", bus.out_valid, 0);
    s = idle();
    s.iv = 1; s.rs1 = 5; s.rs2 = 6;
    step(s);
    post();
    chk("flush_prs1", bus.out_prs1, 32);
    chk("flush_rdy1", bus.out_prs1_rdy, 1);
    chk("flush_rdy2", bus.out_prs2_rdy, 1);

    for (int n = 0; n < 3000; n++) begin
      s.iv   = $urandom_range(0, 3) != 0;
      s.rs1  = 5'($urandom_range(0, 31));
      s.rs2  = 5'($urandom_range(0, 31));
      s.rd   = 5'($urandom_range(0, 31));
      s.we   = $urandom_range(0, 3) != 0;
      s.fav  = $urandom_range(0, 7) != 0;
      s.fap  = 6'($urandom_range(1, 63));
      s.ordy = $urandom_range(0, 3) != 0;
      s.wb   = $urandom_range(0, 1) == 1;
      s.wbp  = 6'($urandom_range(0, 63));
      if (s.wbp == s.fap) s.wbp = 6'((int'(s.fap) % 63) + 1);
      s.ce   = $urandom_range(0, 4) == 0;
      s.crd  = 5'($urandom_range(0, 31));
      s.cph  = 6'($urandom_range(1, 63));
      s.fl   = $urandom_range(0, 39) == 0;
      step(s);
    end

    repeat (3) step(idle());
    post();
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
